// File: rtl/writeback_arbiter_pkg.sv
// rtl/writeback_arbiter_pkg.sv - shared widths and load-queue entry type for the writeback arbiter
package writeback_arbiter_pkg;

  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;

  // One buffered load return: destination register and its data
  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } lq_entry_t;

endpackage

// File: rtl/writeback_arbiter_lq_fifo.sv
// rtl/writeback_arbiter_lq_fifo.sv - load-return FIFO with single push and 0/1/2 pops per cycle
module lq_fifo
  import writeback_arbiter_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  lq_entry_t        push_entry,
  input  logic [1:0]       pop_cnt,
  output lq_entry_t        head,
  output lq_entry_t        head_nxt,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  lq_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Head views come straight from storage, so a fresh push is only visible next cycle
  assign head     = mem[rd_ptr];
  assign head_nxt = mem[rd_ptr + PTR_W'(1)];

  // Entry storage needs no reset; occupancy alone decides what is valid
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks pushes minus pops
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      rd_ptr <= rd_ptr + PTR_W'(pop_cnt);
      count  <= count + CNT_W'(push) - CNT_W'(pop_cnt);
    end
  end

endmodule

// File: rtl/writeback_arbiter.sv
// rtl/writeback_arbiter.sv - two-port register writeback arbiter for ALU lanes and queued load returns
module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int DATA_W   = writeback_arbiter_pkg::DATA_W,
  parameter int ADDR_W   = writeback_arbiter_pkg::ADDR_W,
  parameter int LQ_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                alu_valid_1,
  input  logic [ADDR_W-1:0]   alu_rd_1,
  input  logic [DATA_W-1:0]   alu_data_1,
  input  logic                alu_valid_2,
  input  logic [ADDR_W-1:0]   alu_rd_2,
  input  logic [DATA_W-1:0]   alu_data_2,
  input  logic                ld_issue_valid,
  input  logic [ADDR_W-1:0]   ld_issue_rd,
  input  logic                ld_ret_valid,
  input  logic [ADDR_W-1:0]   ld_ret_rd,
  input  logic [DATA_W-1:0]   ld_ret_data,
  output logic                ld_ret_ready,
  output logic                reg_write_1,
  output logic [ADDR_W-1:0]   rd_1,
  output logic [DATA_W-1:0]   writedata_1,
  output logic                reg_write_2,
  output logic [ADDR_W-1:0]   rd_2,
  output logic [DATA_W-1:0]   writedata_2,
  output logic [NUM_REGS-1:0] busy_mask,
  output logic [2:0]          lq_count
);

  lq_entry_t           ret_entry;
  lq_entry_t           head;
  lq_entry_t           head_nxt;
  logic                push;
  logic [1:0]          pop_cnt;
  logic                ready_q;
  logic                lane1_ok;
  logic                lane2_ok;
  logic                s1_wr;
  logic [ADDR_W-1:0]   s1_rd;
  logic [DATA_W-1:0]   s1_data;
  logic                s2_wr;
  logic [ADDR_W-1:0]   s2_rd;
  logic [DATA_W-1:0]   s2_data;
  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] clr_mask;

  // ready_q holds ld_ret_ready low through reset and for the cycle that ends it
  assign ld_ret_ready = ready_q && (lq_count != 3'(LQ_DEPTH));
  assign push         = ld_ret_valid && ld_ret_ready;
  assign ret_entry    = '{rd: ld_ret_rd, data: ld_ret_data};

  lq_fifo #(
    .DEPTH (LQ_DEPTH),
    .CNT_W (3)
  ) u_lq_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry (ret_entry),
    .pop_cnt    (pop_cnt),
    .head       (head),
    .head_nxt   (head_nxt),
    .count      (lq_count)
  );

  // ALU lanes own their ports; queued loads fill whatever ports are left, oldest first
  always_comb begin
    lane1_ok = alu_valid_1 && (alu_rd_1 != '0);
    lane2_ok = alu_valid_2 && (alu_rd_2 != '0);
    pop_cnt  = 2'd0;
    clr_mask = '0;
    s1_wr    = lane1_ok;
    s1_rd    = alu_rd_1;
    s1_data  = alu_data_1;
    s2_wr    = lane2_ok;
    s2_rd    = alu_rd_2;
    s2_data  = alu_data_2;
    if (!lane1_ok && (lq_count != 3'd0)) begin
      pop_cnt           = 2'd1;
      s1_wr             = (head.rd != '0);
      s1_rd             = head.rd;
      s1_data           = head.data;
      clr_mask[head.rd] = 1'b1;
      if (!lane2_ok && (lq_count >= 3'd2)) begin
        pop_cnt               = 2'd2;
        s2_wr                 = (head_nxt.rd != '0);
        s2_rd                 = head_nxt.rd;
        s2_data               = head_nxt.data;
        clr_mask[head_nxt.rd] = 1'b1;
      end
    end else if (!lane2_ok && (lq_count != 3'd0)) begin
      pop_cnt           = 2'd1;
      s2_wr             = (head.rd != '0);
      s2_rd             = head.rd;
      s2_data           = head.data;
      clr_mask[head.rd] = 1'b1;
    end
  end

  // Issue marks the destination busy; r0 is hardwired and never tracked
  always_comb begin
    set_mask = '0;
    if (ld_issue_valid && (ld_issue_rd != '0)) begin
      set_mask[ld_issue_rd] = 1'b1;
    end
  end

  // Registered write ports; idle ports drop reg_write but keep rd/data
  always_ff @(posedge clk) begin
    if (reset) begin
      reg_write_1 <= 1'b0;
      rd_1        <= '0;
      writedata_1 <= '0;
      reg_write_2 <= 1'b0;
      rd_2        <= '0;
      writedata_2 <= '0;
    end else begin
      reg_write_1 <= s1_wr;
      reg_write_2 <= s2_wr;
      if (s1_wr) begin
        rd_1        <= s1_rd;
        writedata_1 <= s1_data;
      end
      if (s2_wr) begin
        rd_2        <= s2_rd;
        writedata_2 <= s2_data;
      end
    end
  end

  // Scoreboard: set wins over a same-cycle clear of the same register
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_mask <= '0;
      ready_q   <= 1'b0;
    end else begin
      busy_mask <= (busy_mask & ~clr_mask) | set_mask;
      ready_q   <= 1'b1;
    end
  end

  // Upstream must never reissue or write a register that still has a load in flight
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(ld_issue_valid && (ld_issue_rd != '0) && busy_mask[ld_issue_rd]));
      assert (!(alu_valid_1 && (alu_rd_1 != '0) && busy_mask[alu_rd_1]));
      assert (!(alu_valid_2 && (alu_rd_2 != '0) && busy_mask[alu_rd_2]));
    end
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
// tb/tb_writeback_arbiter.sv - directed scoreboard bench for writeback_arbiter
module tb_writeback_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid_1, alu_valid_2;
  logic [4:0]  alu_rd_1, alu_rd_2;
  logic [7:0]  alu_data_1, alu_data_2;
  logic        ld_issue_valid;
  logic [4:0]  ld_issue_rd;
  logic        ld_ret_valid;
  logic [4:0]  ld_ret_rd;
  logic [7:0]  ld_ret_data;
  logic        ld_ret_ready;
  logic        reg_write_1, reg_write_2;
  logic [4:0]  rd_1, rd_2;
  logic [7:0]  writedata_1, writedata_2;
  logic [31:0] busy_mask;
  logic [2:0]  lq_count;

  typedef struct {
    logic [4:0] rd;
    logic [7:0] data;
  } ent_t;

  typedef struct {
    logic        w1;
    logic [4:0]  rd1;
    logic [7:0]  d1;
    logic        w2;
    logic [4:0]  rd2;
    logic [7:0]  d2;
    logic [2:0]  cnt;
    logic [31:0] busy;
    logic        rdy;
  } exp_t;

  ent_t        mq[$];
  exp_t        expq[$];
  logic [31:0] m_busy;
  logic        m_rdy;
  logic [4:0]  h_rd1, h_rd2;
  logic [7:0]  h_d1, h_d2;
  int          checks = 0;
  int          errors = 0;

  writeback_arbiter dut (
    .clk            (clk),
    .reset          (reset),
    .alu_valid_1    (alu_valid_1),
    .alu_rd_1       (alu_rd_1),
    .alu_data_1     (alu_data_1),
    .alu_valid_2    (alu_valid_2),
    .alu_rd_2       (alu_rd_2),
    .alu_data_2     (alu_data_2),
    .ld_issue_valid (ld_issue_valid),
    .ld_issue_rd    (ld_issue_rd),
    .ld_ret_valid   (ld_ret_valid),
    .ld_ret_rd      (ld_ret_rd),
    .ld_ret_data    (ld_ret_data),
    .ld_ret_ready   (ld_ret_ready),
    .reg_write_1    (reg_write_1),
    .rd_1           (rd_1),
    .writedata_1    (writedata_1),
    .reg_write_2    (reg_write_2),
    .rd_2           (rd_2),
    .writedata_2    (writedata_2),
    .busy_mask      (busy_mask),
    .lq_count       (lq_count)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_alu(logic v1, logic [4:0] r1, logic [7:0] d1,
                         logic v2, logic [4:0] r2, logic [7:0] d2);
    alu_valid_1 = v1; alu_rd_1 = r1; alu_data_1 = d1;
    alu_valid_2 = v2; alu_rd_2 = r2; alu_data_2 = d2;
  endtask

  task automatic set_ret(logic v, logic [4:0] r, logic [7:0] d);
    ld_ret_valid = v; ld_ret_rd = r; ld_ret_data = d;
  endtask

  // Predict the next cycle from the model, clock once, then compare against the queued prediction
  task automatic cycle(string tag);
    exp_t e;
    ent_t en;
    int   npop;
    logic p1, p2, push_ok;
    p1 = alu_valid_1 && (alu_rd_1 != 5'd0);
    p2 = alu_valid_2 && (alu_rd_2 != 5'd0);
    e.w1 = 1'b0; e.rd1 = h_rd1; e.d1 = h_d1;
    e.w2 = 1'b0; e.rd2 = h_rd2; e.d2 = h_d2;
    npop = 0;
    push_ok = ld_ret_valid && m_rdy && (mq.size() != 4);
    if (p1) begin
      e.w1 = 1'b1; e.rd1 = alu_rd_1; e.d1 = alu_data_1;
    end else if (mq.size() > 0) begin
      en = mq[0]; npop = 1; m_busy[en.rd] = 1'b0;
      if (en.rd != 5'd0) begin e.w1 = 1'b1; e.rd1 = en.rd; e.d1 = en.data; end
    end
    if (p2) begin
      e.w2 = 1'b1; e.rd2 = alu_rd_2; e.d2 = alu_data_2;
    end else if (mq.size() > npop) begin
      en = mq[npop]; npop++; m_busy[en.rd] = 1'b0;
      if (en.rd != 5'd0) begin e.w2 = 1'b1; e.rd2 = en.rd; e.d2 = en.data; end
    end
    for (int i = 0; i < npop; i++) void'(mq.pop_front());
    if (push_ok) begin
      en.rd = ld_ret_rd; en.data = ld_ret_data;
      mq.push_back(en);
    end
    if (ld_issue_valid && (ld_issue_rd != 5'd0)) m_busy[ld_issue_rd] = 1'b1;
    m_rdy = 1'b1;
    h_rd1 = e.rd1; h_d1 = e.d1; h_rd2 = e.rd2; h_d2 = e.d2;
    e.cnt  = 3'(mq.size());
    e.busy = m_busy;
    e.rdy  = m_rdy && (mq.size() != 4);
    expq.push_back(e);
    @(posedge clk);
    #1;
    e = expq.pop_front();
    check({tag, ".reg_write_1"}, 32'(reg_write_1), 32'(e.w1));
    check({tag, ".rd_1"},        32'(rd_1),        32'(e.rd1));
    check({tag, ".writedata_1"}, 32'(writedata_1), 32'(e.d1));
    check({tag, ".reg_write_2"}, 32'(reg_write_2), 32'(e.w2));
    check({tag, ".rd_2"},        32'(rd_2),        32'(e.rd2));
    check({tag, ".writedata_2"}, 32'(writedata_2), 32'(e.d2));
    check({tag, ".lq_count"},    32'(lq_count),    32'(e.cnt));
    check({tag, ".busy_mask"},   busy_mask,        e.busy);
    check({tag, ".ld_ret_ready"},32'(ld_ret_ready),32'(e.rdy));
  endtask

  task automatic do_reset(string tag);
    reset = 1'b1;
    @(posedge clk);
    #1;
    mq.delete();
    m_busy = '0; m_rdy = 1'b0;
    h_rd1 = '0; h_d1 = '0; h_rd2 = '0; h_d2 = '0;
    check({tag, ".reg_write_1"}, 32'(reg_write_1), 32'd0);
    check({tag, ".rd_1"},        32'(rd_1),        32'd0);
    check({tag, ".writedata_1"}, 32'(writedata_1), 32'd0);
    check({tag, ".reg_write_2"}, 32'(reg_write_2), 32'd0);
    check({tag, ".rd_2"},        32'(rd_2),        32'd0);
    check({tag, ".writedata_2"}, 32'(writedata_2), 32'd0);
    check({tag, ".lq_count"},    32'(lq_count),    32'd0);
    check({tag, ".busy_mask"},   busy_mask,        32'd0);
    check({tag, ".ld_ret_ready"},32'(ld_ret_ready),32'd0);
    reset = 1'b0;
  endtask

  initial begin
    logic [4:0] rds [4];
    reset = 1'b1;
    set_alu(0, 0, 0, 0, 0, 0);
    set_ret(0, 0, 0);
    ld_issue_valid = 1'b0; ld_issue_rd = '0;
    do_reset("reset");
    cycle("post_reset");

    // Both ALU lanes
    set_alu(1, 5'd3, 8'h5A, 1, 5'd7, 8'hA5);
    cycle("alu_pair");
    set_alu(0, 0, 0, 0, 0, 0);
    cycle("alu_idle_hold");

    // Fill the queue while ALU lanes hold both ports, then drain two per cycle
    rds[0] = 5'd4; rds[1] = 5'd5; rds[2] = 5'd6; rds[3] = 5'd9;
    ld_issue_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ld_issue_rd = rds[i];
      cycle("issue");
    end
    ld_issue_valid = 1'b0;
    set_alu(1, 5'd1, 8'h11, 1, 5'd2, 8'h22);
    for (int i = 0; i < 4; i++) begin
      set_ret(1, rds[i], 8'h40 + 8'(i));
      cycle("fill");
    end
    set_ret(0, 0, 0);
    set_alu(0, 0, 0, 0, 0, 0);
    cycle("drain_a");
    cycle("drain_b");
    cycle("drain_idle");

    // Lane 1 busy, lane 2 free: head goes to port 2
    ld_issue_valid = 1'b1;
    ld_issue_rd = 5'd8;  cycle("issue8");
    ld_issue_rd = 5'd10; cycle("issue10");
    ld_issue_valid = 1'b0;
    set_alu(1, 5'd1, 8'h01, 1, 5'd2, 8'h02);
    set_ret(1, 5'd8, 8'h88);  cycle("ret8");
    set_ret(1, 5'd10, 8'hAA); cycle("ret10");
    set_ret(0, 0, 0);
    set_alu(1, 5'd2, 8'h33, 0, 0, 0);
    cycle("partial");
    set_alu(0, 0, 0, 0, 0, 0);
    cycle("partial_tail");

    // Minimum return-to-port latency with an empty queue
    ld_issue_valid = 1'b1; ld_issue_rd = 5'd11; cycle("issue11");
    ld_issue_valid = 1'b0;
    set_ret(1, 5'd11, 8'hB1); cycle("ret11_push");
    set_ret(0, 0, 0);         cycle("ret11_pop");

    // rd=0 filtering on ALU, issue and return
    set_alu(1, 5'd0, 8'hFF, 0, 0, 0);
    ld_issue_valid = 1'b1; ld_issue_rd = 5'd0;
    cycle("alu_rd0");
    ld_issue_valid = 1'b0;
    set_alu(0, 0, 0, 0, 0, 0);
    set_ret(1, 5'd0, 8'h77); cycle("ret_rd0_push");
    set_ret(0, 0, 0);        cycle("ret_rd0_pop");

    // Full queue: a pop does not admit the waiting return until the next cycle
    ld_issue_valid = 1'b1;
    for (int i = 12; i <= 16; i++) begin
      ld_issue_rd = 5'(i);
      cycle("issue_wrap");
    end
    ld_issue_valid = 1'b0;
    set_alu(1, 5'd1, 8'h5C, 1, 5'd2, 8'hC5);
    for (int i = 12; i <= 15; i++) begin
      set_ret(1, 5'(i), 8'hC0 + 8'(i));
      cycle("fill_wrap");
    end
    set_ret(1, 5'd16, 8'hD6);
    set_alu(1, 5'd1, 8'h61, 0, 0, 0);
    cycle("full_pop_no_push");
    set_alu(1, 5'd1, 8'h62, 1, 5'd2, 8'h26);
    cycle("push_after_pop");
    set_ret(0, 0, 0);
    set_alu(0, 0, 0, 0, 0, 0);
    cycle("drain_wrap_a");
    cycle("drain_wrap_b");
    cycle("drain_wrap_c");

    // Reset with three queued returns and busy_mask 0x310
    ld_issue_valid = 1'b1;
    ld_issue_rd = 5'd4; cycle("issue_r4");
    ld_issue_rd = 5'd8; cycle("issue_r8");
    ld_issue_rd = 5'd9; cycle("issue_r9");
    ld_issue_valid = 1'b0;
    set_alu(1, 5'd1, 8'h71, 1, 5'd2, 8'h72);
    set_ret(1, 5'd4, 8'h14); cycle("pre_rst_4");
    set_ret(1, 5'd8, 8'h18); cycle("pre_rst_8");
    set_ret(1, 5'd9, 8'h19); cycle("pre_rst_9");
    set_ret(0, 0, 0);
    set_alu(0, 0, 0, 0, 0, 0);
    do_reset("mid_reset");
    for (int i = 0; i < 4; i++) cycle("after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/writeback_arbiter.md
WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 Parameter: DATA_W, 8, register data width.
REQ-002 Parameter: ADDR_W, 5, register index width (32 registers).
REQ-003 Parameter: LQ_DEPTH, 4, load-return queue entries; power of two, at least 2.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 alu_valid_1 / alu_rd_1 / alu_data_1  in  1/ADDR_W/DATA_W  ALU lane-1 result; always accepted, no ready.
REQ-007 alu_valid_2 / alu_rd_2 / alu_data_2  in  1/ADDR_W/DATA_W  ALU lane-2 result; lane 2 is younger than lane 1; always accepted, no ready.
REQ-008 ld_issue_valid / ld_issue_rd  in  1/ADDR_W  a load is issued to the memory unit with destination ld_issue_rd.
REQ-009 ld_ret_valid / ld_ret_rd / ld_ret_data  in  1/ADDR_W/DATA_W  load-return data from memory.
REQ-010 ld_ret_ready  out  1  queue can accept a return this cycle.
REQ-011 reg_write_1 / rd_1 / writedata_1  out  1/ADDR_W/DATA_W  register-file write port 1.
REQ-012 reg_write_2 / rd_2 / writedata_2  out  1/ADDR_W/DATA_W  register-file write port 2; the register file gives port 2 priority when rd_1 equals rd_2.
REQ-013 busy_mask  out  32  bit n set while a load to register n is outstanding; the issue stage stalls dependents on it.
REQ-014 lq_count  out  3  current queue occupancy, 0..LQ_DEPTH.

Function
REQ-015 All write-port outputs shall be registered: a result accepted in cycle N appears on its port in cycle N+1.
REQ-016 ALU lane 1 shall own port 1 and lane 2 shall own port 2 whenever the lane is valid with rd != 0.
REQ-017 An ALU result with rd == 0 shall be discarded: the port stays free and reg_write stays 0.
REQ-018 A load return shall be pushed into the FIFO queue when ld_ret_valid and ld_ret_ready are both 1; a return with rd == 0 is pushed and later popped, but asserts no write.
REQ-019 ld_ret_ready shall equal (lq_count != LQ_DEPTH), computed from the registered count; no same-cycle pop-through.
REQ-020 Each cycle, queue entries shall pop in FIFO order into the ports left free by the ALU lanes: head to port 1 if free, else port 2; a second entry to port 2 if both ports are free; at most 2 pops per cycle.
REQ-021 When both ports are taken by ALU lanes, no pop shall occur and the queue holds.
REQ-022 A pushed entry shall be poppable no earlier than the cycle after the push; minimum load-return-to-port latency is 2 cycles.
REQ-023 Simultaneous push and pop(s) shall update lq_count by pushes minus pops; the pointers wrap modulo LQ_DEPTH.
REQ-024 busy_mask[r] shall set on ld_issue_valid with ld_issue_rd == r != 0, and shall clear in the cycle the entry for r is popped.
REQ-025 Same-cycle set and clear of one bit shall resolve to set; bit 0 shall never set.
REQ-026 A load issue to an already-busy register, or an ALU result to a busy register, is illegal upstream; the arbiter takes no corrective action, and an assertion shall flag it.
REQ-027 A port that receives no source in a cycle shall drive reg_write = 0, while rd and writedata hold their previous values.

Reset
REQ-028 While reset is high at a clock edge, the following shall be cleared: all outputs to 0, busy_mask to 0, lq_count and both pointers to 0, ld_ret_ready to 0.
REQ-029 After reset, ld_ret_ready shall return to 1 in the first cycle following deassertion.
REQ-030 Reset mid-operation shall discard all queued returns and outstanding busy bits with no writes issued.

Structure
REQ-031 DATA_W, ADDR_W, the register count (32) and the queue-entry struct (rd, data) shall live in the shared defines package.
REQ-032 The load-return queue shall be a sub-module, lq_fifo, with push, a pop count of 0/1/2, head, head+1 and count.
REQ-033 Port allocation and the scoreboard shall be in the top level; no other sub-modules.

Verification
REQ-034 ALU only: lane1 rd=3 data=0x5A, lane2 rd=7 data=0xA5 in cycle N -> cycle N+1: reg_write_1=1 rd_1=3 writedata_1=0x5A, reg_write_2=1 rd_2=7 writedata_2=0xA5.
REQ-035 Load fill/drain: issue rd=4, then 5, 6, 9; all busy bits set; four returns while both ALU lanes are busy -> lq_count=4, ld_ret_ready=0; ALU goes idle -> two pops per cycle, ports show rd 4/5 then 6/9, busy_mask back to 0.
REQ-036 Partial port: lane1 valid rd=2, lane2 idle, queue head rd=8 -> next cycle port 1 writes rd=2 and port 2 writes rd=8; lq_count drops by 1.
REQ-037 rd=0 filtering: ALU lane1 rd=0 data=0xFF -> reg_write_1 stays 0; a load return with rd=0 is popped with no write, and busy_mask is unchanged.
REQ-038 Reset with lq_count=3 and busy_mask=0x0000_0310 -> next cycle: all counts, masks and reg_writes are 0, and no write of a queued entry ever appears.
REQ-039 Push/pop on a full queue: a pop occurs while ld_ret_valid=1 -> no push that cycle; the push is accepted the next cycle, with pointer wrap checked against a scoreboard model.
